m_uart_loader: RTL and testbench
================================

Name: m_uart_loader

Overview:
- Serial program loader that writes the instruction/data memory image of the 5-stage processor from a host over an 8N1 UART line.
- It is the write side of the memory image the processor later fetches.
- It receives a 32-bit word count, then that many 32-bit little-endian words, and writes them to consecutive word addresses through a single-cycle write port (addr/we/din).
- r_done releases the processor from reset once the image is loaded.

Parameters:
- SERIAL_WCNT, 434, clock cycles per serial bit (50 MHz / 115200 baud); minimum 4.
- ADDR_W, 12, word-address width of the target memory (4K words).

Ports:
- w_clk  input  1  system clock
- w_rst  input  1  synchronous active-high reset
- w_rxd  input  1  asynchronous serial input, idle high
- r_we  output  1  memory write enable, one-cycle pulse per word
- r_addr  output  ADDR_W  memory word address for the write
- r_data  output  32  memory write data
- r_done  output  1  image fully loaded; sticky until reset
- r_ferr  output  1  framing error seen; sticky until reset
- r_wcnt  output  32  number of words written so far

Behaviour:
- Reset values: r_we=0, r_addr=0, r_data=0, r_done=0, r_ferr=0, r_wcnt=0. All FSMs go to idle and the partial byte/word/length is discarded. Reset mid-transfer aborts cleanly; the next byte is treated as length byte 0.
- Input sync: w_rxd passes through a 2-flop synchronizer, reset to 1. All sampling uses the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronized rxd==0; baud counter cleared.
  - START: at count SERIAL_WCNT/2 (integer divide), resample. If rxd==0 -> DATA with counter cleared. If rxd==1 -> IDLE (glitch reject, no byte).
  - DATA: sample every SERIAL_WCNT cycles, 8 bits, LSB first. After bit 7 -> STOP.
  - STOP: sample after SERIAL_WCNT cycles. If rxd==1, the byte is valid: internal byte strobe for one cycle, -> IDLE. If rxd==0, set r_ferr, drop the byte, -> IDLE without waiting for the line to go high. The byte index is not advanced.
- Loader FSM states: LEN, WORD, DONE.
  - LEN: collect 4 bytes little-endian (first byte = bits 7:0) into the length N. On the 4th byte: if N==0 -> DONE, with r_done=1 the next cycle; else -> WORD.
  - WORD: collect 4 bytes little-endian into a word. The cycle after the 4th byte strobe: r_we=1 for exactly one cycle, with r_data = the word and r_addr = the current address.
  - After each write, the cycle after r_we: r_addr increments by 1 and r_wcnt increments by 1.
  - Address wraps modulo 2^ADDR_W; for N > 2^ADDR_W, later words overwrite earlier ones. This is required behaviour, not an error.
  - When r_wcnt reaches N, the FSM goes to DONE. r_done rises in the same cycle that r_wcnt becomes N.
  - DONE: r_done=1. Incoming bytes are received but ignored; no further r_we.
- r_addr and r_data hold their last values when r_we=0.
- Latency from the stop-bit sample of the last byte of a word to r_we is 1 cycle.
- Each byte strobe is consumed in the same cycle; there is no buffering. Back-to-back bytes need no idle time beyond one stop bit.
- Simultaneous w_rst and byte strobe: reset wins and the byte is lost.

Test Plan (SERIAL_WCNT=8 for simulation):
- Length/word decode: send bytes 02 00 00 00, 78 56 34 12, EF BE AD DE -> r_we pulses with (addr 0, data 0x12345678) and then (addr 1, data 0xDEADBEEF). r_wcnt=2, r_done=1 one cycle after the 2nd write, r_ferr=0.
- Zero-length image: send 00 00 00 00 -> no r_we, r_done=1 on the cycle after the 4th stop-bit sample; later bytes AA BB produce no write.
- Glitch and framing errors:
  - A 2-cycle low pulse on w_rxd yields no byte.
  - A byte 0x55 with the stop bit driven 0 sets r_ferr=1 and is dropped.
  - Resending 0x55 correctly then counts as the same byte position; the word assembles correctly.
- Mid-word reset: send length 1, then 11 22, assert w_rst for 1 cycle -> all outputs 0. Resend 01 00 00 00, 44 33 22 11 -> single write, addr 0, data 0x11223344.
- Wrap-around with ADDR_W=2: send length 5 and words 1..5 -> writes to addresses 0,1,2,3,0; the 5th write has data 5 at addr 0; r_wcnt=5, r_done=1.

Source files
------------

// File: rtl/m_uart_loader.sv
`timescale 1ns / 1ps
// UART (8N1) program loader: receives a 32-bit word count followed by that many
// little-endian 32-bit words and writes them to consecutive memory word addresses.
module m_uart_loader #(
   parameter int unsigned SERIAL_WCNT = 434,
   parameter int unsigned ADDR_W      = 12
) (
   input  logic              w_clk,
   input  logic              w_rst,
   input  logic              w_rxd,
   output logic              r_we,
   output logic [ADDR_W-1:0] r_addr,
   output logic [31:0]       r_data,
   output logic              r_done,
   output logic              r_ferr,
   output logic [31:0]       r_wcnt
);

   localparam int unsigned CntW = $clog2(SERIAL_WCNT);
   localparam logic [CntW-1:0] HalfCnt = CntW'(SERIAL_WCNT / 2);
   localparam logic [CntW-1:0] BitCnt  = CntW'(SERIAL_WCNT - 1);

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   typedef enum logic [1:0] {LdLen, LdWord, LdDone} ld_state_e;

   logic            rxd_meta_q, rxd_q;
   rx_state_e       rx_state_q, rx_state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            ferr_q, ferr_d;
   logic            byte_vld;

   ld_state_e       ld_state_q, ld_state_d;
   logic [1:0]      bidx_q, bidx_d;
   logic [31:0]     len_q, len_d;
   logic [23:0]     word_q, word_d;
   logic            we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]     data_q, data_d;
   logic            done_q, done_d;
   logic [31:0]     wcnt_q, wcnt_d;

   // Receiver: start bit is re-checked mid-bit, then every bit is sampled near its centre.
   always_comb begin
      rx_state_d = rx_state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      ferr_d     = ferr_q;
      byte_vld   = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (!rxd_q) begin
               rx_state_d = RxStart;
               cnt_d      = '0;
            end
         end
         RxStart: begin
            if (cnt_q == HalfCnt) begin
               cnt_d      = '0;
               bit_d      = '0;
               rx_state_d = rxd_q ? RxIdle : RxData;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RxData: begin
            if (cnt_q == BitCnt) begin
               cnt_d   = '0;
               shift_d = {rxd_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  rx_state_d = RxStop;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RxStop: begin
            if (cnt_q == BitCnt) begin
               cnt_d      = '0;
               rx_state_d = RxIdle;
               if (rxd_q) begin
                  byte_vld = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   // Loader: bytes shift in from the top so the first byte ends up in bits 7:0.
   always_comb begin
      ld_state_d = ld_state_q;
      bidx_d     = bidx_q;
      len_d      = len_q;
      word_d     = word_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      done_d     = done_q;
      wcnt_d     = wcnt_q;

      if (we_q) begin
         addr_d = addr_q + ADDR_W'(1);
         wcnt_d = wcnt_q + 32'd1;
         if ((wcnt_q + 32'd1) == len_q) begin
            done_d     = 1'b1;
            ld_state_d = LdDone;
         end
      end

      unique case (ld_state_q)
         LdLen: begin
            if (byte_vld) begin
               bidx_d = bidx_q + 2'd1;
               len_d  = {shift_q, len_q[31:8]};
               if (bidx_q == 2'd3) begin
                  if ({shift_q, len_q[31:8]} == 32'd0) begin
                     done_d     = 1'b1;
                     ld_state_d = LdDone;
                  end else begin
                     ld_state_d = LdWord;
                  end
               end
            end
         end
         LdWord: begin
            if (byte_vld) begin
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  we_d   = 1'b1;
                  data_d = {shift_q, word_q};
               end else begin
                  word_d = {shift_q, word_q[23:8]};
               end
            end
         end
         LdDone: begin
         end
         default: ld_state_d = LdLen;
      endcase
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         rxd_meta_q <= 1'b1;
         rxd_q      <= 1'b1;
         rx_state_q <= RxIdle;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         ferr_q     <= 1'b0;
         ld_state_q <= LdLen;
         bidx_q     <= '0;
         len_q      <= '0;
         word_q     <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         wcnt_q     <= '0;
      end else begin
         rxd_meta_q <= w_rxd;
         rxd_q      <= rxd_meta_q;
         rx_state_q <= rx_state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         ferr_q     <= ferr_d;
         ld_state_q <= ld_state_d;
         bidx_q     <= bidx_d;
         len_q      <= len_d;
         word_q     <= word_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         done_q     <= done_d;
         wcnt_q     <= wcnt_d;
      end
   end

   assign r_we   = we_q;
   assign r_addr = addr_q;
   assign r_data = data_q;
   assign r_done = done_q;
   assign r_ferr = ferr_q;
   assign r_wcnt = wcnt_q;

endmodule

// File: tb/tb_m_uart_loader.sv
`timescale 1ns / 1ps
// Scoreboard bench for m_uart_loader: a byte-stream model predicts every memory write,
// and an independent monitor checks writes and completion as the DUT presents them.
module tb_m_uart_loader;

   localparam int unsigned W  = 8;
   localparam int unsigned AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          rxd;
   logic          we;
   logic [AW-1:0] addr;
   logic [31:0]   data;
   logic          done;
   logic          ferr;
   logic [31:0]   wcnt;

   m_uart_loader #(
      .SERIAL_WCNT(W),
      .ADDR_W     (AW)
   ) dut (
      .w_clk (clk),
      .w_rst (rst),
      .w_rxd (rxd),
      .r_we  (we),
      .r_addr(addr),
      .r_data(data),
      .r_done(done),
      .r_ferr(ferr),
      .r_wcnt(wcnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   wr_t         exp_q[$];
   logic [7:0]  rx_bytes[$];
   logic [31:0] m_n = 0;
   bit          m_ferr = 0;

   function automatic void check(string name, longint unsigned act, longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Reference model: the image is just the accepted byte stream split into 4-byte groups.
   function automatic void model_byte(logic [7:0] b);
      int n;
      int k;
      wr_t w;
      rx_bytes.push_back(b);
      n = rx_bytes.size();
      if (n == 4) begin
         m_n = {rx_bytes[3], rx_bytes[2], rx_bytes[1], rx_bytes[0]};
      end else if (n > 4 && (n % 4) == 0) begin
         k = n / 4 - 1;
         if (longint'(k) <= longint'(m_n)) begin
            w.addr = AW'(k - 1);
            w.data = {rx_bytes[n-1], rx_bytes[n-2], rx_bytes[n-3], rx_bytes[n-4]};
            exp_q.push_back(w);
         end
      end
   endfunction

   // Monitor
   wr_t got;
   bit  prev_we = 0;
   bit  prev_done = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (we) begin
            check("we_pulse_width", prev_we, 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0h data %0h, none expected", addr, data);
            end else begin
               got = exp_q.pop_front();
               check("write_addr", addr, got.addr);
               check("write_data", data, got.data);
            end
         end
         if (done && !prev_done && m_n != 0) begin
            check("done_after_last_we", prev_we, 1);
            check("wcnt_at_done", wcnt, m_n);
         end
      end
      prev_we   = we;
      prev_done = done;
   end

   task automatic hold(input logic v, input int n);
      rxd = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit good);
      if (good) model_byte(b);
      else m_ferr = 1;
      hold(1'b0, W);
      for (int i = 0; i < 8; i++) hold(b[i], W);
      hold(good, W);
      if (!good) hold(1'b1, 2 * W);
   endtask

   task automatic send_bytes(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) send_byte(v[8*i +: 8], 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("reset_we", we, 0);
      check("reset_addr", addr, 0);
      check("reset_data", data, 0);
      check("reset_done", done, 0);
      check("reset_ferr", ferr, 0);
      check("reset_wcnt", wcnt, 0);
      rst = 1'b0;
      exp_q.delete();
      rx_bytes.delete();
      m_n    = 0;
      m_ferr = 0;
   endtask

   task automatic final_check();
      int     k;
      longint ew;
      bit     ed;
      hold(1'b1, 4 * W);
      k  = (rx_bytes.size() >= 4) ? rx_bytes.size() / 4 - 1 : 0;
      ew = (longint'(k) < longint'(m_n)) ? longint'(k) : longint'(m_n);
      ed = (rx_bytes.size() >= 4) && (longint'(k) >= longint'(m_n));
      check("final_wcnt", wcnt, ew);
      check("final_done", done, ed);
      check("final_ferr", ferr, m_ferr);
      check("writes_outstanding", exp_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] n;
      logic [31:0] wv;
      rst = 1'b1;
      rxd = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      do_reset();

      // Two-word image
      send_bytes(64'h12345678_00000002, 8);
      send_bytes(64'hDEADBEEF, 4);
      final_check();

      // Zero-length image, trailing bytes ignored
      do_reset();
      send_bytes(64'h00000000, 4);
      hold(1'b1, 2);
      check("zero_len_done", done, 1);
      send_bytes(64'hBBAA, 2);
      final_check();

      // Glitch, then framing error with retransmission
      do_reset();
      hold(1'b0, 2);
      hold(1'b1, 2 * W);
      send_bytes(64'h00000001, 4);
      send_byte(8'h55, 0);
      check("ferr_set", ferr, 1);
      send_byte(8'h55, 1);
      send_bytes(64'h887766, 3);
      final_check();

      // Reset in the middle of a word
      do_reset();
      send_bytes(64'h2211_00000001, 6);
      hold(1'b1, W);
      rx_bytes.delete();
      do_reset();
      send_bytes(64'h11223344_00000001, 8);
      final_check();

      // Address wrap: five words into a four-word memory
      do_reset();
      send_bytes(64'h00000005, 4);
      for (int i = 1; i <= 5; i++) send_bytes(64'(i), 4);
      final_check();

      // Randomized images with random inter-byte gaps and trailing junk
      for (int it = 0; it < 6; it++) begin
         do_reset();
         n = $urandom_range(1, 6);
         send_bytes(64'(n), 4);
         for (int j = 0; j < int'(n); j++) begin
            wv = $urandom;
            for (int b = 0; b < 4; b++) begin
               send_byte(wv[8*b +: 8], 1);
               hold(1'b1, $urandom_range(0, 3));
            end
         end
         send_bytes(64'($urandom_range(0, 65535)), 2);
         final_check();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
